// File: rtl/reset_seq_pkg.sv
// Shared state encoding and stage-index width for the reset sequencer.
package reset_seq_pkg;

    localparam int CUR_STAGE_W = 3;

    typedef enum logic [2:0] {
        ST_HOLD,
        ST_WAIT_RDY,
        ST_GAP,
        ST_DONE,
        ST_FAULT
    } seq_state_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating cycle counter: load clears, enable advances, done flags count == limit-1.
module seq_timer #(
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] limit_i,
    output logic         done_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    assign done_o = (cnt_q == (limit_i - ONE));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = '0;
        else if (en_i && !done_o && (cnt_q != '1))
            cnt_d = cnt_q + ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold all domains, then release them in ascending order as each
// reports ready. Define RESET_SEQUENCER_WATCHDOG_EN to add the per-stage ready watchdog.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int NUM_STAGES     = 3,
    parameter int HOLD_CYCLES    = 8,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   pclk,
    input  logic                   rst,
    input  logic                   soft_rst_req,
    input  logic [NUM_STAGES-1:0]  stage_rdy,
    output logic [NUM_STAGES-1:0]  stage_rst,
    output logic                   soft_rst_ack,
    output logic                   all_ready,
    output logic [CUR_STAGE_W-1:0] cur_stage,
    output logic                   timeout_err
);

    localparam int PH_W = $clog2(max2(HOLD_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [PH_W-1:0] HOLD_LIM = PH_W'(HOLD_CYCLES);
    localparam logic [PH_W-1:0] GAP_LIM  = PH_W'(GAP_CYCLES);
    localparam logic [CUR_STAGE_W-1:0] LAST_STAGE = CUR_STAGE_W'(NUM_STAGES - 1);
    localparam logic [CUR_STAGE_W-1:0] STAGE_ONE  = CUR_STAGE_W'(1);

    seq_state_e             state_q, state_d;
    logic [NUM_STAGES-1:0]  stage_rst_q, stage_rst_d;
    logic                   all_ready_q, all_ready_d;
    logic                   ack_q, ack_d;
    logic [CUR_STAGE_W-1:0] cur_stage_q, cur_stage_d;
    logic [CUR_STAGE_W-1:0] nxt_stage;
    logic                   armed_q, armed_d;
    logic                   rdy_k;
    logic                   ph_done;
    logic                   tmr_load;

    assign tmr_load  = (state_d != state_q);
    assign nxt_stage = cur_stage_q + STAGE_ONE;

    seq_timer #(.W(PH_W)) u_phase_tmr (
        .clk_i   (pclk),
        .rst_i   (rst),
        .load_i  (tmr_load),
        .en_i    ((state_q == ST_HOLD) || (state_q == ST_GAP)),
        .limit_i ((state_q == ST_HOLD) ? HOLD_LIM : GAP_LIM),
        .done_o  (ph_done)
    );

`ifdef RESET_SEQUENCER_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic wd_done;
    logic timeout_q, timeout_d;

    seq_timer #(.W(WD_W)) u_wd_tmr (
        .clk_i   (pclk),
        .rst_i   (rst),
        .load_i  (tmr_load),
        .en_i    (state_q == ST_WAIT_RDY),
        .limit_i (WD_W'(TIMEOUT_CYCLES)),
        .done_o  (wd_done)
    );
    assign timeout_err = timeout_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        rdy_k = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++)
            if (cur_stage_q == CUR_STAGE_W'(i)) rdy_k = stage_rdy[i];
    end

    always_comb begin
        state_d     = state_q;
        stage_rst_d = stage_rst_q;
        all_ready_d = all_ready_q;
        ack_d       = 1'b0;
        cur_stage_d = cur_stage_q;
        // Re-arm only once the requester has dropped its level after an ack.
        armed_d     = armed_q | ~soft_rst_req;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
        timeout_d   = timeout_q;
`endif
        case (state_q)
            ST_HOLD: begin
                if (ph_done) begin
                    state_d        = ST_WAIT_RDY;
                    stage_rst_d[0] = 1'b0;
                    cur_stage_d    = '0;
                end
            end
            ST_WAIT_RDY: begin
                if (rdy_k) begin
                    if (cur_stage_q == LAST_STAGE) begin
                        state_d     = ST_DONE;
                        all_ready_d = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
`ifdef RESET_SEQUENCER_WATCHDOG_EN
                else if (wd_done) begin
                    state_d     = ST_FAULT;
                    stage_rst_d = '1;
                    timeout_d   = 1'b1;
                    all_ready_d = 1'b0;
                end
`endif
            end
            ST_GAP: begin
                if (ph_done) begin
                    state_d     = ST_WAIT_RDY;
                    cur_stage_d = nxt_stage;
                    for (int i = 0; i < NUM_STAGES; i++)
                        if (nxt_stage == CUR_STAGE_W'(i)) stage_rst_d[i] = 1'b0;
                end
            end
            ST_DONE, ST_FAULT: begin
                if (soft_rst_req && armed_q) begin
                    state_d     = ST_HOLD;
                    ack_d       = 1'b1;
                    armed_d     = 1'b0;
                    stage_rst_d = '1;
                    all_ready_d = 1'b0;
                    cur_stage_d = '0;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
                    timeout_d   = 1'b0;
`endif
                end
            end
            default: state_d = ST_HOLD;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q     <= ST_HOLD;
            stage_rst_q <= '1;
            all_ready_q <= 1'b0;
            ack_q       <= 1'b0;
            cur_stage_q <= '0;
            armed_q     <= 1'b1;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
            timeout_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            stage_rst_q <= stage_rst_d;
            all_ready_q <= all_ready_d;
            ack_q       <= ack_d;
            cur_stage_q <= cur_stage_d;
            armed_q     <= armed_d;
`ifdef RESET_SEQUENCER_WATCHDOG_EN
            timeout_q   <= timeout_d;
`endif
        end
    end

    assign stage_rst    = stage_rst_q;
    assign all_ready    = all_ready_q;
    assign soft_rst_ack = ack_q;
    assign cur_stage    = cur_stage_q;

endmodule

// File: doc/reset_sequencer.md
RESET_SEQUENCER -- requirements
Module: reset_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of sequenced reset domains (1..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 8, cycles all stage resets stay asserted after rst falls (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 4, cycles between a stage reporting ready and the next stage release (>=1).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 1024, watchdog limit per stage (>=2).
REQ-005 SHALL have port pclk  input  1  single clock, all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset, driven from the delayed-lock reset.
REQ-007 SHALL have port soft_rst_req  input  1  level request to re-run the sequence, held until acked.
REQ-008 SHALL have port stage_rdy  input  NUM_STAGES  per-stage "initialised" flag.
REQ-009 SHALL have port stage_rst  output  NUM_STAGES  per-stage active-high reset, registered.
REQ-010 SHALL have port soft_rst_ack  output  1  one-cycle acceptance pulse.
REQ-011 SHALL have port all_ready  output  1  high when every stage has been released and reported ready.
REQ-012 SHALL have port cur_stage  output  3  index of the stage being released or awaited.
REQ-013 SHALL have port timeout_err  output  1  sticky watchdog fault flag.

Function
REQ-014 SHALL implement FSM states HOLD, WAIT_RDY, GAP, DONE and FAULT, all outputs registered.
REQ-015 Edge 1 is the first rising edge with rst sampled low. HOLD SHALL exit at edge HOLD_CYCLES into WAIT_RDY(0), clearing stage_rst[0] on that same edge.
REQ-016 WAIT_RDY(k) SHALL leave on the first edge sampling stage_rdy[k]=1: to DONE if k=NUM_STAGES-1, else to GAP.
REQ-017 GAP SHALL last exactly GAP_CYCLES cycles, then enter WAIT_RDY(k+1), clearing stage_rst[k+1] on the entry edge and setting cur_stage=k+1.
REQ-018 Stages SHALL be released strictly in ascending index order; a released stage SHALL stay released until a sequence restart.
REQ-019 On entry to DONE, all_ready SHALL be set; it SHALL stay high in DONE regardless of later stage_rdy changes.
REQ-020 In DONE or FAULT, soft_rst_req=1 SHALL produce soft_rst_ack=1 for one cycle. On the same edge it SHALL set stage_rst to all ones, clear all_ready, clear timeout_err, set cur_stage=0 and enter HOLD.
REQ-021 soft_rst_req SHALL be ignored in HOLD, WAIT_RDY and GAP. The request stays pending and is acked on the first DONE/FAULT cycle.
REQ-022 A second ack SHALL not issue until soft_rst_req has been sampled low at least once after the previous ack.
REQ-023 Counters SHALL be sized $clog2 of their limit plus 1 and SHALL never wrap; each counter clears on every state entry.

Reset
REQ-024 With rst=1 at an edge, the block SHALL force state=HOLD, counter=0, stage_rst=all ones, all_ready=0, soft_rst_ack=0, cur_stage=0 and timeout_err=0.
REQ-025 rst SHALL override every state mid-sequence, including DONE and FAULT, with identical results.

Configuration
REQ-026 With macro RESET_SEQUENCER_WATCHDOG_EN defined, WAIT_RDY SHALL count cycles.
REQ-027 In that case, reaching TIMEOUT_CYCLES without stage_rdy[k] SHALL enter FAULT: stage_rst all ones, timeout_err=1, all_ready=0, cur_stage held at k.
REQ-028 Without the macro, WAIT_RDY SHALL wait indefinitely, timeout_err SHALL be constant 0, FAULT SHALL be unreachable and no watchdog counter SHALL be synthesised.

Structure
REQ-029 State encodings and the cur_stage width SHALL live in shared package reset_seq_pkg.
REQ-030 Cycle counting (HOLD, GAP and watchdog) SHALL use one sub-module, seq_timer, with load/enable/done and a width parameter.

Verification (NUM_STAGES=3, HOLD=8, GAP=4, TIMEOUT=64)
REQ-031 Nominal release: rst falls, stage_rdy=3'b111 -> stage_rst[0]=0 @edge 8, [1]=0 @13, [2]=0 @18, all_ready=1 @19.
REQ-032 Slow stage: stage_rdy[1] rises 20 cycles after stage_rst[1] falls -> stage_rst[2] stays 1 until 4 cycles after the rdy edge; no error.
REQ-033 Watchdog (macro on): stage_rdy[2] held 0 -> FAULT 64 cycles after WAIT_RDY(2) entry: stage_rst=3'b111, timeout_err=1, cur_stage=2. Macro off: stalls, timeout_err=0.
REQ-034 Soft reset: req=1 during GAP -> no ack; on DONE entry a one-cycle ack, stage_rst=3'b111, full sequence repeats. Holding req high yields no second ack.
REQ-035 Reset mid-operation: rst=1 for one cycle in WAIT_RDY(1) -> next cycle stage_rst=3'b111, cur_stage=0, all outputs at reset values; the sequence restarts from HOLD.
